// File: rtl/uc_min_pq_if.sv
// Engine/arbiter-facing bundle of the per-engine implied-unit-clause queue.
// The master side drives push/flush/pop; the slave side (the queue) drives head and status.
interface uc_min_pq_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LIT_W = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
);
  logic             eng2pq_push;
  logic [LIT_W-1:0] eng2pq_lit;
  logic             eng2pq_flush;
  logic             uca2eng_pop;
  logic [LIT_W-1:0] pq2uca_min;
  logic             pq2uca_valid;
  logic             pq2uca_empty;
  logic             pq2eng_full;
  logic             pq2eng_overflow;
  logic [CNT_W-1:0] pq_count;

  modport master (
    output eng2pq_push, eng2pq_lit, eng2pq_flush, uca2eng_pop,
    input  pq2uca_min, pq2uca_valid, pq2uca_empty, pq2eng_full, pq2eng_overflow, pq_count
  );

  modport slave (
    input  eng2pq_push, eng2pq_lit, eng2pq_flush, uca2eng_pop,
    output pq2uca_min, pq2uca_valid, pq2uca_empty, pq2eng_full, pq2eng_overflow, pq_count
  );
endinterface

// File: rtl/uc_min_pq.sv
// Sorted min-queue of implied literals; slot 0 always holds the smallest live entry.
// Duplicates are dropped; a full push without a same-cycle pop sets a sticky overflow.
module uc_min_pq #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LIT_W = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  uc_min_pq_if.slave    pq
);
  typedef logic [LIT_W-1:0] lit_t;

  lit_t             r_slot [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  lit_t             w_ps  [DEPTH];
  logic [DEPTH-1:0] w_pv;
  logic [DEPTH-1:0] w_lt;
  lit_t             w_sp  [DEPTH];
  logic [DEPTH-1:0] w_vp;
  logic [DEPTH-1:0] w_ltp;
  lit_t             w_ns  [DEPTH];
  logic [DEPTH-1:0] w_nv;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_ovf_nxt;
  logic             w_dup;
  logic             w_pop_eff;
  logic             w_room;
  logic             w_accept;

  always_comb begin
    w_dup = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_slot[i] == pq.eng2pq_lit)) w_dup = 1'b1;
    end
    w_pop_eff = pq.uca2eng_pop && r_vld[0];
    w_room    = !r_vld[DEPTH-1] || w_pop_eff;
    w_accept  = pq.eng2pq_push && !w_dup && w_room;
    w_ovf_nxt = r_ovf || (pq.eng2pq_push && !w_dup && !w_room);
    w_count_nxt = r_count + CNT_W'(w_accept) - CNT_W'(w_pop_eff);
  end

  // Insertion runs on the post-pop view so push+pop behaves as remove-then-insert.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      w_ps[i] = w_pop_eff ? r_slot[i+1] : r_slot[i];
      w_pv[i] = w_pop_eff ? r_vld[i+1]  : r_vld[i];
    end
    w_ps[DEPTH-1] = w_pop_eff ? '0   : r_slot[DEPTH-1];
    w_pv[DEPTH-1] = w_pop_eff ? 1'b0 : r_vld[DEPTH-1];

    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_lt[i] = w_pv[i] && (w_ps[i] < pq.eng2pq_lit);
    end

    w_sp[0]  = '0;
    w_vp[0]  = 1'b1;
    w_ltp[0] = 1'b1;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      w_sp[i]  = w_ps[i-1];
      w_vp[i]  = w_pv[i-1];
      w_ltp[i] = w_lt[i-1];
    end

    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_ns[i] = w_ps[i];
      w_nv[i] = w_pv[i];
      if (w_accept) begin
        w_nv[i] = w_pv[i] || w_vp[i];
        if (w_lt[i])       w_ns[i] = w_ps[i];
        else if (w_ltp[i]) w_ns[i] = pq.eng2pq_lit;
        else               w_ns[i] = w_sp[i];
      end
      if (!w_nv[i]) w_ns[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_slot[i] <= '0;
      r_vld   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (pq.eng2pq_flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_slot[i] <= '0;
      r_vld   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) r_slot[i] <= w_ns[i];
      r_vld   <= w_nv;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign pq.pq2uca_min      = r_slot[0];
  assign pq.pq2uca_valid    = r_vld[0];
  assign pq.pq2uca_empty    = !r_vld[0];
  assign pq.pq2eng_full     = r_vld[DEPTH-1];
  assign pq.pq2eng_overflow = r_ovf;
  assign pq.pq_count        = r_count;
endmodule
